branch_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 36 +++
 rtl/bp_sat_counter32.sv | 39 +++
 rtl/branch_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_predictor.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
//   ctr_t        : 2-bit saturating direction counter.
//   CTR_*        : named counter states (strongly/weakly not-taken/taken).
//   STAT_MAX     : ceiling of the 32-bit statistics counters.
//   sat_ctr_next : next counter value after a resolved outcome.
package bp_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'd0;
  localparam ctr_t CTR_WNT = 2'd1;
  localparam ctr_t CTR_WT  = 2'd2;
  localparam ctr_t CTR_ST  = 2'd3;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  // Move one step toward the observed outcome, clamping at both ends.
  function automatic ctr_t sat_ctr_next(ctr_t c, logic taken);
    ctr_t n;
    if (taken) begin
      if (c == CTR_ST) begin
        n = CTR_ST;
      end else begin
        n = c + 2'd1;
      end
    end else begin
      if (c == CTR_SNT) begin
        n = CTR_SNT;
      end else begin
        n = c - 2'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bp_sat_counter32.sv
// Saturating 32-bit event counter used for the predictor statistics.
//   clk     : rising-edge clock.
//   rst     : asynchronous active-high reset, clears the count.
//   inc_i   : count one event this cycle.
//   count_o : current count, holds at 32'hFFFF_FFFF instead of wrapping.
module bp_sat_counter32
  import bp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_i,
  output logic [31:0] count_o
);

  logic [31:0] count_q;
  logic [31:0] count_d;

  // Next count: step on an event unless already at the ceiling.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != STAT_MAX)) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with a 2-bit direction counter per entry.
//   clk, rst                       : clock, asynchronous active-high reset.
//   lookup_pc                      : fetch PC, predicted in the same cycle.
//   pred_hit/pred_taken/pred_target: prediction; target falls back to pc+4.
//   update_valid/_pc/_taken/_target: resolved conditional branch from execute.
//   clear                          : invalidate every entry on the next edge.
//   branch_count/mispredict_count  : saturating statistics.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int   XLEN     = 32,
  parameter int   ENTRIES  = 16,
  parameter ctr_t CTR_INIT = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            update_valid,
  input  logic [XLEN-1:0] update_pc,
  input  logic            update_taken,
  input  logic [XLEN-1:0] update_target,
  input  logic            clear,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [XLEN-1:0] PC_STEP = {{(XLEN-3){1'b0}}, 3'b100};

  // Entry table, one array per field.
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];
  ctr_t               ctr_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             u_pt;
  logic             mispredict;
  logic             unused_pc_bits;

  // Instruction-aligned PCs: the two low bits never select anything.
  assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
  assign u_idx  = update_pc[IDX_W+1:2];
  assign u_tag  = update_pc[XLEN-1:IDX_W+2];

  // Fetch-side prediction straight from the registered table (no bypass).
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && ctr_q[lk_idx][1];
    if (pred_taken) begin
      pred_target = target_q[lk_idx];
    end else begin
      pred_target = lookup_pc + PC_STEP;
    end
  end

  // Re-derive what was predicted for the resolved branch and grade it;
  // a taken/taken pair still mispredicts when the target moved.
  always_comb begin
    u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_pt       = u_hit && ctr_q[u_idx][1];
    mispredict = (u_pt != update_taken) ||
                 (u_pt && update_taken && (target_q[u_idx] != update_target));
  end

  // Table next state: clear wins over a same-cycle update.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    ctr_d    = ctr_q;
    target_d = target_q;
    if (clear) begin
      valid_d = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_d[i] = CTR_INIT;
      end
    end else if (update_valid) begin
      if (u_hit) begin
        ctr_d[u_idx] = sat_ctr_next(ctr_q[u_idx], update_taken);
        if (update_taken) begin
          target_d[u_idx] = update_target;
        end else begin
          target_d[u_idx] = target_q[u_idx];
        end
      end else if (update_taken) begin
        // Allocate over whatever occupies the slot, starting weakly taken.
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = update_target;
        ctr_d[u_idx]    = CTR_WT;
      end else begin
        valid_d = valid_q;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  // Table registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        ctr_q[i]    <= CTR_INIT;
        target_q[i] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      ctr_q    <= ctr_d;
      target_q <= target_d;
    end
  end

  // Statistics count every report, including one that a clear discards.
  bp_sat_counter32 u_branch_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (update_valid),
    .count_o (branch_count)
  );

  bp_sat_counter32 u_mis_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (update_valid && mispredict),
    .count_o (mispredict_count)
  );

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        clear;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  int n_vec  = 0;
  int n_miss = 0;

  branch_predictor #(.XLEN(32), .ENTRIES(16), .CTR_INIT(2'b01)) dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .pred_hit         (pred_hit),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_target    (update_target),
    .clear            (clear),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each slot remembers the full word address (pc>>2) of its branch.
  bit          m_valid [16];
  logic [31:0] m_line  [16];
  int          m_ctr   [16];
  logic [31:0] m_tgt   [16];
  longint      m_bc;
  longint      m_mc;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_line[i]  = 32'd0;
      m_ctr[i]   = 1;
      m_tgt[i]   = 32'd0;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_predict(input logic [31:0] pc, output logic h, output logic t,
                               output logic [31:0] tg);
    int idx;
    idx = int'((pc >> 2) & 32'hF);
    h   = m_valid[idx] && (m_line[idx] == (pc >> 2));
    t   = h && (m_ctr[idx] >= 2);
    tg  = t ? m_tgt[idx] : pc + 32'd4;
  endtask

  task automatic model_update(input logic uv, input logic [31:0] upc, input logic ut,
                              input logic [31:0] utgt, input logic clr);
    logic h, pt;
    logic [31:0] st;
    int idx;
    if (uv) begin
      model_predict(upc, h, pt, st);
      idx = int'((upc >> 2) & 32'hF);
      if (m_bc < 64'hFFFF_FFFF) m_bc++;
      if ((pt != ut) || (pt && ut && (st != utgt))) begin
        if (m_mc < 64'hFFFF_FFFF) m_mc++;
      end
      if (!clr) begin
        if (h) begin
          if (ut) begin
            m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
            m_tgt[idx] = utgt;
          end else begin
            m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
          end
        end else if (ut) begin
          m_valid[idx] = 1'b1;
          m_line[idx]  = upc >> 2;
          m_tgt[idx]   = utgt;
          m_ctr[idx]   = 2;
        end
      end
    end
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 1;
      end
    end
  endtask

  // Drive one cycle, compare against the model before the edge, then advance the model.
  task automatic run_step(input logic uv, input logic [31:0] upc, input logic ut,
                          input logic [31:0] utgt, input logic clr, input logic [31:0] lpc,
                          input string tag);
    logic h, t;
    logic [31:0] tg;
    @(negedge clk);
    update_valid  = uv;
    update_pc     = upc;
    update_taken  = ut;
    update_target = utgt;
    clear         = clr;
    lookup_pc     = lpc;
    #1;
    model_predict(lpc, h, t, tg);
    chk({tag, " hit"},    {31'd0, pred_hit},   {31'd0, h});
    chk({tag, " taken"},  {31'd0, pred_taken}, {31'd0, t});
    chk({tag, " target"}, pred_target,         tg);
    chk({tag, " bcount"}, branch_count,        m_bc[31:0]);
    chk({tag, " mcount"}, mispredict_count,    m_mc[31:0]);
    @(posedge clk);
    model_update(uv, upc, ut, utgt, clr);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    update_valid = 1'b0;
    clear = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        clr;
    logic [31:0] lpc;
    logic        hit;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] bc;
    logic [31:0] mc;
  } vec_t;

  vec_t tbl [18];

  logic [31:0] hi_tab [4];

  initial begin
    hi_tab[0] = 32'h0000_0000;
    hi_tab[1] = 32'h0000_0040;
    hi_tab[2] = 32'h0000_0080;
    hi_tab[3] = 32'hFFFF_FFC0;

    // Expectations are seen before the edge that applies the row's update.
    //            uv    upc           ut    utgt          clr   lpc           hit   tk    tgt           bc     mc
    tbl[0]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'd0};
    tbl[1]  = '{1'b1, 32'h0000_000C, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 32'h0000_0010, 32'd0, 32'd0};
    tbl[2]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b1, 1'b1, 32'h0000_0014, 32'd1, 32'd1};
    tbl[3]  = '{1'b1, 32'h0000_000C, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_000C, 1'b1, 1'b1, 32'h0000_0014, 32'd1, 32'd1};
    tbl[4]  = '{1'b1, 32'h0000_000C, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_000C, 1'b1, 1'b1, 32'h0000_0014, 32'd2, 32'd1};
    tbl[5]  = '{1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b1, 1'b1, 32'h0000_0014, 32'd3, 32'd1};
    tbl[6]  = '{1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b1, 1'b1, 32'h0000_0014, 32'd4, 32'd2};
    tbl[7]  = '{1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_0010, 32'd5, 32'd3};
    tbl[8]  = '{1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_0010, 32'd6, 32'd3};
    tbl[9]  = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b1, 1'b0, 32'h0000_0010, 32'd7, 32'd3};
    tbl[10] = '{1'b1, 32'h0000_004C, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_004C, 1'b0, 1'b0, 32'h0000_0050, 32'd7, 32'd3};
    tbl[11] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, 1'b0, 1'b0, 32'h0000_0010, 32'd8, 32'd4};
    tbl[12] = '{1'b1, 32'h0000_004C, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_004C, 1'b1, 1'b1, 32'h0000_0100, 32'd8, 32'd4};
    tbl[13] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_004C, 1'b1, 1'b1, 32'h0000_0200, 32'd9, 32'd5};
    tbl[14] = '{1'b1, 32'h0000_0020, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_004C, 1'b1, 1'b1, 32'h0000_0200, 32'd9, 32'd5};
    tbl[15] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_004C, 1'b0, 1'b0, 32'h0000_0050, 32'd10, 32'd6};
    tbl[16] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0024, 32'd10, 32'd6};
    tbl[17] = '{1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000, 32'd10, 32'd6};

    // Reset state, observed while rst is still high.
    rst           = 1'b1;
    lookup_pc     = 32'h0000_000C;
    update_valid  = 1'b0;
    update_pc     = 32'd0;
    update_taken  = 1'b0;
    update_target = 32'd0;
    clear         = 1'b0;
    model_reset();
    #2;
    chk("reset hit",    {31'd0, pred_hit},   32'd0);
    chk("reset taken",  {31'd0, pred_taken}, 32'd0);
    chk("reset target", pred_target,         32'h0000_0010);
    chk("reset bcount", branch_count,        32'd0);
    chk("reset mcount", mispredict_count,    32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      update_valid  = tbl[i].uv;
      update_pc     = tbl[i].upc;
      update_taken  = tbl[i].ut;
      update_target = tbl[i].utgt;
      clear         = tbl[i].clr;
      lookup_pc     = tbl[i].lpc;
      #1;
      chk($sformatf("row%0d hit", i),    {31'd0, pred_hit},   {31'd0, tbl[i].hit});
      chk($sformatf("row%0d taken", i),  {31'd0, pred_taken}, {31'd0, tbl[i].tk});
      chk($sformatf("row%0d target", i), pred_target,         tbl[i].tgt);
      chk($sformatf("row%0d bcount", i), branch_count,        tbl[i].bc);
      chk($sformatf("row%0d mcount", i), mispredict_count,    tbl[i].mc);
    end

    // Randomized traffic over a small PC pool so hits, aliases and clears all occur.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] upc, lpc, utgt;
      upc  = hi_tab[$urandom_range(0, 3)] | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      lpc  = hi_tab[$urandom_range(0, 3)] | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      utgt = ($urandom_range(0, 1) == 0) ? 32'h0000_1000 + ($urandom_range(0, 3) << 2) : $urandom;
      run_step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, upc, 1'($urandom_range(0, 1)), utgt,
               ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, lpc, $sformatf("rand%0d", n));
    end

    // Mispredict counter saturation from a preloaded near-full value.
    do_reset();
    @(negedge clk);
    force dut.u_mis_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_mis_cnt.count_q;
    m_mc = 64'h0000_0000_FFFF_FFFE;
    run_step(1'b1, 32'h0000_000C, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_000C, "sat1");
    run_step(1'b1, 32'h0000_000C, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, "sat2");
    run_step(1'b1, 32'h0000_000C, 1'b1, 32'h0000_0014, 1'b0, 32'h0000_000C, "sat3");
    run_step(1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_000C, "sat4");

    // Asynchronous reset between edges, with an update still being offered.
    @(negedge clk);
    update_valid  = 1'b1;
    update_pc     = 32'h0000_000C;
    update_taken  = 1'b1;
    update_target = 32'h0000_0014;
    lookup_pc     = 32'h0000_000C;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst bcount", branch_count,        32'd0);
    chk("midrst mcount", mispredict_count,    32'd0);
    chk("midrst hit",    {31'd0, pred_hit},   32'd0);
    chk("midrst target", pred_target,         32'h0000_0010);
    @(negedge clk);
    update_valid = 1'b0;
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
